ddr_cmd_arb: RTL and testbench

Multi-channel command arbiter placed in front of the frame-buffer DDR write/read controller. Up to `NUM_CH` frame-buffer channels share one write-command port and one read-command port. Each direction has an independent round-robin arbiter. A grant is held from command issue until command done, and write-data and read-data are steered to the granted channel. This lets several video streams (for example multiple inputs for a mosaic output) share one AXI DDR port.

---
 rtl/ddr_cmd_arb.sv | 192 +++++++++++++++++++
 tb/tb_ddr_cmd_arb.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_arb.sv
// Round-robin write/read command arbiter sharing one DDR controller port among NUM_CH channels.
// Optional macro ARB_RD_PRIO_EN gives read channel 0 (display scan-out) absolute priority.

module ddr_cmd_arb_dir #(
    parameter int NUM_CH        = 4,
    parameter int AW            = 28,
    parameter int LW            = 32,
    parameter bit PRIO0         = 1'b0,
    parameter bit DATA_IN_ISSUE = 1'b1
) (
    input  logic                        ddr_clk,
    input  logic                        ddr_rst,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH*AW-1:0]        addr,
    input  logic [NUM_CH*LW-1:0]        len,
    input  logic                        cmd_ready,
    input  logic                        cmd_done,
    output logic                        cmd_en,
    output logic [AW-1:0]               cmd_addr,
    output logic [LW-1:0]               cmd_len,
    output logic [NUM_CH-1:0]           rdy,
    output logic [NUM_CH-1:0]           done,
    output logic [$clog2(NUM_CH)-1:0]   grant,
    output logic                        data_gate
);
    localparam int IW = $clog2(NUM_CH);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] ptr, ptr_nxt, grant_nxt;
    logic [IW-1:0] winner, idx;
    logic          found;

    // First set request at or above ptr, wrapping; channel 0 overrides when PRIO0.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        found  = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = ptr + IW'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
        if (PRIO0 && req[0]) winner = '0;
    end

    always_ff @(posedge ddr_clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values, avoiding simulation races.
        if (ddr_rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            grant <= grant_nxt;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no branch can infer a latch.
        state_nxt = state;
        ptr_nxt   = ptr;
        grant_nxt = grant;
        cmd_en    = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rdy       = '0;
        done      = '0;
        data_gate = DATA_IN_ISSUE ? (state != IDLE) : (state == BUSY);
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_nxt = winner;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                cmd_en      = req[grant];
                cmd_addr    = addr[int'(grant)*AW +: AW];
                cmd_len     = len[int'(grant)*LW +: LW];
                rdy[grant]  = cmd_ready;
                if (!req[grant]) begin
                    state_nxt = IDLE;
                end else if (cmd_ready && cmd_done) begin
                    done[grant] = 1'b1;
                    state_nxt   = IDLE;
                    ptr_nxt     = grant + IW'(1);
                end else if (cmd_ready) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                done[grant] = cmd_done;
                if (cmd_done) begin
                    state_nxt = IDLE;
                    ptr_nxt   = grant + IW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

module ddr_cmd_arb #(
    parameter int NUM_CH          = 4,
    parameter int CTRL_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH       = 32,
    parameter int MEM_DQ_WIDTH    = 32
) (
    input  logic                                ddr_clk,
    input  logic                                ddr_rst,
    input  logic [NUM_CH-1:0]                   ch_wr_req,
    input  logic [NUM_CH*CTRL_ADDR_WIDTH-1:0]   ch_wr_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]         ch_wr_len,
    output logic [NUM_CH-1:0]                   ch_wr_rdy,
    output logic [NUM_CH-1:0]                   ch_wr_done,
    output logic [NUM_CH-1:0]                   ch_wr_data_req,
    input  logic [NUM_CH*8*MEM_DQ_WIDTH-1:0]    ch_wr_data,
    input  logic [NUM_CH-1:0]                   ch_rd_req,
    input  logic [NUM_CH*CTRL_ADDR_WIDTH-1:0]   ch_rd_addr,
    input  logic [NUM_CH*LEN_WIDTH-1:0]         ch_rd_len,
    output logic [NUM_CH-1:0]                   ch_rd_rdy,
    output logic [NUM_CH-1:0]                   ch_rd_done,
    output logic [NUM_CH-1:0]                   ch_rd_data_en,
    output logic [8*MEM_DQ_WIDTH-1:0]           ch_rd_data,
    output logic                                m_wr_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0]          m_wr_cmd_addr,
    output logic [LEN_WIDTH-1:0]                m_wr_cmd_len,
    input  logic                                m_wr_cmd_ready,
    input  logic                                m_wr_cmd_done,
    input  logic                                m_wr_data_re,
    output logic [8*MEM_DQ_WIDTH-1:0]           m_wr_data,
    output logic                                m_rd_cmd_en,
    output logic [CTRL_ADDR_WIDTH-1:0]          m_rd_cmd_addr,
    output logic [LEN_WIDTH-1:0]                m_rd_cmd_len,
    input  logic                                m_rd_cmd_ready,
    input  logic                                m_rd_cmd_done,
    input  logic                                m_rd_en,
    input  logic [8*MEM_DQ_WIDTH-1:0]           m_rd_data,
    output logic [$clog2(NUM_CH)-1:0]           wr_grant,
    output logic [$clog2(NUM_CH)-1:0]           rd_grant
);
    localparam int DW = 8 * MEM_DQ_WIDTH;

`ifdef ARB_RD_PRIO_EN
    localparam bit RD_PRIO = 1'b1;
`else
    localparam bit RD_PRIO = 1'b0;
`endif

    logic wr_gate, rd_gate;

    ddr_cmd_arb_dir #(
        .NUM_CH(NUM_CH), .AW(CTRL_ADDR_WIDTH), .LW(LEN_WIDTH),
        .PRIO0(1'b0), .DATA_IN_ISSUE(1'b1)
    ) u_wr (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .req(ch_wr_req), .addr(ch_wr_addr), .len(ch_wr_len),
        .cmd_ready(m_wr_cmd_ready), .cmd_done(m_wr_cmd_done),
        .cmd_en(m_wr_cmd_en), .cmd_addr(m_wr_cmd_addr), .cmd_len(m_wr_cmd_len),
        .rdy(ch_wr_rdy), .done(ch_wr_done), .grant(wr_grant), .data_gate(wr_gate)
    );

    // Read data enable is only meaningful once the command has been accepted.
    ddr_cmd_arb_dir #(
        .NUM_CH(NUM_CH), .AW(CTRL_ADDR_WIDTH), .LW(LEN_WIDTH),
        .PRIO0(RD_PRIO), .DATA_IN_ISSUE(1'b0)
    ) u_rd (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .req(ch_rd_req), .addr(ch_rd_addr), .len(ch_rd_len),
        .cmd_ready(m_rd_cmd_ready), .cmd_done(m_rd_cmd_done),
        .cmd_en(m_rd_cmd_en), .cmd_addr(m_rd_cmd_addr), .cmd_len(m_rd_cmd_len),
        .rdy(ch_rd_rdy), .done(ch_rd_done), .grant(rd_grant), .data_gate(rd_gate)
    );

    always_comb begin
        ch_wr_data_req = '0;
        m_wr_data      = '0;
        ch_rd_data_en  = '0;
        if (wr_gate) begin
            ch_wr_data_req[wr_grant] = m_wr_data_re;
            m_wr_data                = ch_wr_data[int'(wr_grant)*DW +: DW];
        end
        if (rd_gate) ch_rd_data_en[rd_grant] = m_rd_en;
    end

    assign ch_rd_data = m_rd_data;
endmodule

// File: tb/tb_ddr_cmd_arb.sv
// Randomized self-checking bench for ddr_cmd_arb; a transaction-level model predicts grants.
// Compile with ARB_RD_PRIO_EN defined to also exercise read channel-0 priority.

module tb_ddr_cmd_arb;
    localparam int N  = 4;
    localparam int AW = 28;
    localparam int LW = 32;
    localparam int DW = 256;

`ifdef ARB_RD_PRIO_EN
    localparam bit RD_PRIO = 1'b1;
`else
    localparam bit RD_PRIO = 1'b0;
`endif

    logic              ddr_clk = 1'b0;
    logic              ddr_rst;
    logic [N-1:0]      ch_wr_req, ch_wr_rdy, ch_wr_done, ch_wr_data_req;
    logic [N*AW-1:0]   ch_wr_addr, ch_rd_addr;
    logic [N*LW-1:0]   ch_wr_len, ch_rd_len;
    logic [N*DW-1:0]   ch_wr_data;
    logic [N-1:0]      ch_rd_req, ch_rd_rdy, ch_rd_done, ch_rd_data_en;
    logic [DW-1:0]     ch_rd_data, m_wr_data, m_rd_data;
    logic              m_wr_cmd_en, m_wr_cmd_ready, m_wr_cmd_done, m_wr_data_re;
    logic              m_rd_cmd_en, m_rd_cmd_ready, m_rd_cmd_done, m_rd_en;
    logic [AW-1:0]     m_wr_cmd_addr, m_rd_cmd_addr;
    logic [LW-1:0]     m_wr_cmd_len, m_rd_cmd_len;
    logic [1:0]        wr_grant, rd_grant;

    logic [AW-1:0] wa [N];
    logic [AW-1:0] ra [N];
    logic [LW-1:0] wl [N];
    logic [LW-1:0] rl [N];
    logic [DW-1:0] wd [N];

    int checks = 0;
    int errors = 0;
    int wr_ptr_m = 0;
    int rd_ptr_m = 0;

    ddr_cmd_arb dut (
        .ddr_clk(ddr_clk), .ddr_rst(ddr_rst),
        .ch_wr_req(ch_wr_req), .ch_wr_addr(ch_wr_addr), .ch_wr_len(ch_wr_len),
        .ch_wr_rdy(ch_wr_rdy), .ch_wr_done(ch_wr_done), .ch_wr_data_req(ch_wr_data_req),
        .ch_wr_data(ch_wr_data),
        .ch_rd_req(ch_rd_req), .ch_rd_addr(ch_rd_addr), .ch_rd_len(ch_rd_len),
        .ch_rd_rdy(ch_rd_rdy), .ch_rd_done(ch_rd_done), .ch_rd_data_en(ch_rd_data_en),
        .ch_rd_data(ch_rd_data),
        .m_wr_cmd_en(m_wr_cmd_en), .m_wr_cmd_addr(m_wr_cmd_addr), .m_wr_cmd_len(m_wr_cmd_len),
        .m_wr_cmd_ready(m_wr_cmd_ready), .m_wr_cmd_done(m_wr_cmd_done),
        .m_wr_data_re(m_wr_data_re), .m_wr_data(m_wr_data),
        .m_rd_cmd_en(m_rd_cmd_en), .m_rd_cmd_addr(m_rd_cmd_addr), .m_rd_cmd_len(m_rd_cmd_len),
        .m_rd_cmd_ready(m_rd_cmd_ready), .m_rd_cmd_done(m_rd_cmd_done),
        .m_rd_en(m_rd_en), .m_rd_data(m_rd_data),
        .wr_grant(wr_grant), .rd_grant(rd_grant)
    );

    always #5 ddr_clk = ~ddr_clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = set request at the smallest circular distance from the pointer.
    function automatic int ref_pick(input logic [N-1:0] r, input int p, input bit prio);
        int best = -1;
        int bd   = N;
        if (prio && r[0]) return 0;
        for (int c = 0; c < N; c++) begin
            if (r[c] && ((c - p + N) % N) < bd) begin
                bd   = (c - p + N) % N;
                best = c;
            end
        end
        return best;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_buses();
        for (int c = 0; c < N; c++) begin
            ch_wr_addr[c*AW +: AW] = wa[c];
            ch_wr_len[c*LW +: LW]  = wl[c];
            ch_wr_data[c*DW +: DW] = wd[c];
            ch_rd_addr[c*AW +: AW] = ra[c];
            ch_rd_len[c*LW +: LW]  = rl[c];
        end
    endtask

    task automatic new_payload();
        for (int c = 0; c < N; c++) begin
            wa[c] = AW'($urandom);
            ra[c] = AW'($urandom);
            wl[c] = $urandom;
            rl[c] = $urandom;
            wd[c] = rand_word();
        end
        drive_buses();
    endtask

    // Called at a negedge with the write FSM idle; returns one negedge after done.
    task automatic wr_txn(input logic [N-1:0] r, input int busy, input bit same, input bit hold);
        int w = ref_pick(r, wr_ptr_m, 1'b0);
        ch_wr_req = r;
        @(negedge ddr_clk);
        check("wr_cmd_en", m_wr_cmd_en, 1);
        check("wr_grant", wr_grant, w);
        check("wr_cmd_addr", m_wr_cmd_addr, wa[w]);
        check("wr_cmd_len", m_wr_cmd_len, wl[w]);
        m_wr_cmd_ready = 1'b1;
        m_wr_data_re   = 1'b1;
        m_wr_cmd_done  = same;
        #1;
        check("wr_rdy", ch_wr_rdy, 4'b1 << w);
        check("wr_data_req", ch_wr_data_req, 4'b1 << w);
        check("wr_data", m_wr_data, wd[w]);
        if (same) begin
            check("wr_done_same", ch_wr_done, 4'b1 << w);
        end else begin
            @(negedge ddr_clk);
            m_wr_cmd_ready = 1'b0;
            for (int i = 0; i < busy; i++) begin
                #1;
                check("wr_busy_en", m_wr_cmd_en, 0);
                check("wr_busy_done", ch_wr_done, 0);
                @(negedge ddr_clk);
            end
            m_wr_cmd_done = 1'b1;
            #1;
            check("wr_done", ch_wr_done, 4'b1 << w);
            check("wr_busy_dreq", ch_wr_data_req, 4'b1 << w);
        end
        wr_ptr_m = (w + 1) % N;
        @(negedge ddr_clk);
        m_wr_cmd_ready = 1'b0;
        m_wr_cmd_done  = 1'b0;
        #1;
        check("wr_idle_en", m_wr_cmd_en, 0);
        check("wr_idle_dreq", ch_wr_data_req, 0);
        m_wr_data_re = 1'b0;
        if (!hold) ch_wr_req = '0;
    endtask

    task automatic rd_txn(input logic [N-1:0] r, input int busy, input bit same, input bit hold);
        int w = ref_pick(r, rd_ptr_m, RD_PRIO);
        ch_rd_req = r;
        @(negedge ddr_clk);
        check("rd_cmd_en", m_rd_cmd_en, 1);
        check("rd_grant", rd_grant, w);
        check("rd_cmd_addr", m_rd_cmd_addr, ra[w]);
        check("rd_cmd_len", m_rd_cmd_len, rl[w]);
        m_rd_cmd_ready = 1'b1;
        m_rd_en        = 1'b1;
        m_rd_cmd_done  = same;
        #1;
        check("rd_rdy", ch_rd_rdy, 4'b1 << w);
        check("rd_issue_den", ch_rd_data_en, 0);
        if (same) begin
            check("rd_done_same", ch_rd_done, 4'b1 << w);
        end else begin
            @(negedge ddr_clk);
            m_rd_cmd_ready = 1'b0;
            for (int i = 0; i < busy; i++) begin
                m_rd_en   = 1'($urandom_range(0, 1));
                m_rd_data = rand_word();
                #1;
                check("rd_busy_den", ch_rd_data_en, m_rd_en ? (4'b1 << w) : 4'b0);
                check("rd_data", ch_rd_data, m_rd_data);
                check("rd_busy_en", m_rd_cmd_en, 0);
                @(negedge ddr_clk);
            end
            m_rd_en       = 1'b1;
            m_rd_cmd_done = 1'b1;
            #1;
            check("rd_done", ch_rd_done, 4'b1 << w);
            check("rd_done_den", ch_rd_data_en, 4'b1 << w);
        end
        rd_ptr_m = (w + 1) % N;
        @(negedge ddr_clk);
        m_rd_cmd_ready = 1'b0;
        m_rd_cmd_done  = 1'b0;
        m_rd_en        = 1'b1;
        #1;
        check("rd_idle_en", m_rd_cmd_en, 0);
        check("rd_idle_den", ch_rd_data_en, 0);
        m_rd_en = 1'b0;
        if (!hold) ch_rd_req = '0;
    endtask

    // Granted read request withdrawn before ready: back to idle, pointer untouched.
    task automatic rd_abort(input logic [N-1:0] r);
        int w = ref_pick(r, rd_ptr_m, RD_PRIO);
        ch_rd_req = r;
        @(negedge ddr_clk);
        check("abort_en", m_rd_cmd_en, 1);
        check("abort_grant", rd_grant, w);
        ch_rd_req = '0;
        #1;
        check("abort_drop_en", m_rd_cmd_en, 0);
        @(negedge ddr_clk);
        #1;
        check("abort_idle_en", m_rd_cmd_en, 0);
    endtask

    initial begin
        ddr_rst        = 1'b1;
        ch_wr_req      = '1;
        ch_rd_req      = '1;
        m_wr_cmd_ready = 1'b1;
        m_wr_cmd_done  = 1'b1;
        m_wr_data_re   = 1'b1;
        m_rd_cmd_ready = 1'b1;
        m_rd_cmd_done  = 1'b1;
        m_rd_en        = 1'b1;
        m_rd_data      = '0;
        new_payload();

        // Reset state with every input active
        repeat (2) @(negedge ddr_clk);
        #1;
        check("rst_wr_en", m_wr_cmd_en, 0);
        check("rst_rd_en", m_rd_cmd_en, 0);
        check("rst_wr_rdy", ch_wr_rdy, 0);
        check("rst_wr_done", ch_wr_done, 0);
        check("rst_rd_rdy", ch_rd_rdy, 0);
        check("rst_rd_done", ch_rd_done, 0);
        check("rst_dreq", ch_wr_data_req, 0);
        check("rst_den", ch_rd_data_en, 0);
        check("rst_wr_data", m_wr_data, 0);
        check("rst_wr_addr", m_wr_cmd_addr, 0);
        check("rst_wr_grant", wr_grant, 0);
        check("rst_rd_grant", rd_grant, 0);
        @(negedge ddr_clk);
        ddr_rst        = 1'b0;
        ch_wr_req      = '0;
        ch_rd_req      = '0;
        m_wr_cmd_ready = 1'b0;
        m_wr_cmd_done  = 1'b0;
        m_wr_data_re   = 1'b0;
        m_rd_cmd_ready = 1'b0;
        m_rd_cmd_done  = 1'b0;
        m_rd_en        = 1'b0;
        @(negedge ddr_clk);

        // Single write request on channel 2, then pointer must sit at 3
        new_payload();
        wa[2] = 28'h0001000;
        wl[2] = 32'd128;
        drive_buses();
        wr_txn(4'b0100, 2, 1'b0, 1'b0);
        wr_txn(4'b1111, 0, 1'b0, 1'b0);

        // Concurrent write on 1 and read on 2
        fork
            wr_txn(4'b0010, 1, 1'b0, 1'b0);
            rd_txn(4'b0100, 2, 1'b0, 1'b0);
        join

        // Abort on channel 3 keeps pointer at 3
        rd_abort(4'b1000);
        rd_txn(4'b1110, 1, 1'b0, 1'b0);

        // Same-cycle ready and done on both sides
        wr_txn(4'b1111, 0, 1'b1, 1'b1);
        wr_txn(4'b1111, 1, 1'b0, 1'b0);
        rd_txn(4'b0110, 0, 1'b1, 1'b0);
        rd_txn(4'b0110, 1, 1'b0, 1'b0);

        // Randomized traffic on both directions
        for (int it = 0; it < 16; it++) begin
            new_payload();
            fork
                wr_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), 1'b0);
                rd_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3),
                       ($urandom_range(0, 3) == 0), 1'b0);
            join
        end

        // Reset while a write on channel 2 is in BUSY
        ch_wr_req = 4'b0010;
        @(negedge ddr_clk);
        wr_ptr_m = 2;
        ch_wr_req = 4'b0100;
        m_wr_cmd_ready = 1'b1;
        @(negedge ddr_clk);
        m_wr_cmd_ready = 1'b0;
        ch_wr_req = 4'b0100;
        @(negedge ddr_clk);
        m_wr_cmd_ready = 1'b1;
        @(negedge ddr_clk);
        m_wr_cmd_ready = 1'b0;
        m_wr_data_re   = 1'b1;
        m_wr_cmd_done  = 1'b0;
        #1;
        check("pre_rst_grant", wr_grant, 2);
        check("pre_rst_dreq", ch_wr_data_req, 4'b0100);
        ddr_rst       = 1'b1;
        m_wr_cmd_done = 1'b1;
        @(negedge ddr_clk);
        #1;
        check("mid_rst_en", m_wr_cmd_en, 0);
        check("mid_rst_grant", wr_grant, 0);
        check("mid_rst_dreq", ch_wr_data_req, 0);
        check("mid_rst_done", ch_wr_done, 0);
        check("mid_rst_data", m_wr_data, 0);
        ddr_rst       = 1'b0;
        ch_wr_req     = '0;
        m_wr_cmd_done = 1'b0;
        m_wr_data_re  = 1'b0;
        wr_ptr_m      = 0;
        rd_ptr_m      = 0;
        @(negedge ddr_clk);

        // Fairness with all write requests held: 0,1,2,3,0
        new_payload();
        for (int k = 0; k < 5; k++) wr_txn(4'b1111, 1, 1'b0, (k != 4));

`ifdef ARB_RD_PRIO_EN
        // Channel 0 keeps winning reads while requesting, then round-robin over 1..3
        for (int k = 0; k < 3; k++) rd_txn(4'b1111, 1, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) rd_txn(4'b1110, 1, 1'b0, (k != 2));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
